usr_shift_reg: RTL

Parametrised universal shift register, the successor to the single-bit D flip-flop stage. Holds a WIDTH-bit word and supports hold, logical/arithmetic shifts, rotates, parallel load and clear. A shift counter with a done flag lets the block act as a serialiser/deserialiser front end on register-level datapaths.

---
 rtl/usr_shift_reg_if.sv | 33 +++
 rtl/usr_shift_reg.sv | 95 +++++++++
 2 files changed

// File: rtl/usr_shift_reg_if.sv
// Bus bundle for the universal shift register: control/data inputs and the
// register-side observation outputs. clk and reset stay plain module ports.
// Handshake: there is no valid/ready pair. en is the sole qualifier; every
// rising clk edge with en == 1 commits the operation selected by mode, and
// the block never applies back-pressure.
interface usr_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             done;

  // Driver side (bench or upstream datapath).
  modport master (
    output en, mode, sin_r, sin_l, d,
    input  q, sout_r, sout_l, cnt, done
  );

  // Register side.
  modport slave (
    input  en, mode, sin_r, sin_l, d,
    output q, sout_r, sout_l, cnt, done
  );
endinterface

// File: rtl/usr_shift_reg.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates,
// parallel load and clear, with a saturating shift counter and done flag
// so the block can serialise or deserialise a WIDTH-bit word.
module usr_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  usr_shift_reg_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_inc;

  // Saturating increment shared by every shift/rotate mode.
  assign cnt_inc = (cnt_r < CNT_MAX) ? cnt_r + 1'b1 : cnt_r;

  // Next-state selection by mode; en gating is applied in the register.
  always_comb begin
    q_nxt   = q_r;
    cnt_nxt = cnt_r;
    case (mode_e'(bus.mode))
      MODE_HOLD: begin
        q_nxt   = q_r;
        cnt_nxt = cnt_r;
      end
      MODE_SHR: begin
        q_nxt   = {bus.sin_r, q_r[WIDTH-1:1]};
        cnt_nxt = cnt_inc;
      end
      MODE_SHL: begin
        q_nxt   = {q_r[WIDTH-2:0], bus.sin_l};
        cnt_nxt = cnt_inc;
      end
      MODE_LOAD: begin
        q_nxt   = bus.d;
        cnt_nxt = '0;
      end
      MODE_ROR: begin
        q_nxt   = {q_r[0], q_r[WIDTH-1:1]};
        cnt_nxt = cnt_inc;
      end
      MODE_ROL: begin
        q_nxt   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        cnt_nxt = cnt_inc;
      end
      MODE_ASR: begin
        q_nxt   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        cnt_nxt = cnt_inc;
      end
      MODE_CLR: begin
        q_nxt   = '0;
        cnt_nxt = '0;
      end
      default: begin
        q_nxt   = q_r;
        cnt_nxt = cnt_r;
      end
    endcase
  end

  // Register and counter: asynchronous clear, update only when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r   <= '0;
      cnt_r <= '0;
    end else if (bus.en) begin
      q_r   <= q_nxt;
      cnt_r <= cnt_nxt;
    end
  end

  // Serial taps show the bit the next SHR / SHL would discard.
  assign bus.q      = q_r;
  assign bus.sout_r = q_r[0];
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.cnt    = cnt_r;
  assign bus.done   = (cnt_r == CNT_MAX);
endmodule
